// File: rtl/filter_comm_pkg.sv
// Shared line-format constants and receiver state encoding for the filter result link.
// Used by both the filter-side transmitter and the host-side result_word_rx.
package filter_comm_pkg;

    localparam int CLK_HZ_DEF   = 50_000_000;
    localparam int BAUD_DEF     = 115_200;
    localparam int WORD_BYTES   = 5;
    localparam int WORD_W       = 8 * WORD_BYTES;
    localparam int ADDR_W       = 10;
    localparam int TIMEOUT_BITS = 20;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clock cycles per bit period; integer truncation is intended.
    function automatic int bit_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/result_word_rx_if.sv
// Result word bus from result_word_rx towards a capture RAM or checker.
interface result_word_rx_if #(
    parameter int WORD_W = filter_comm_pkg::WORD_W,
    parameter int ADDR_W = filter_comm_pkg::ADDR_W
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic [ADDR_W-1:0] wr_address;
    logic              frame_err;
    logic              timeout_err;

    modport master (output word_data, word_valid, wr_address, frame_err, timeout_err);
    modport slave  (input  word_data, word_valid, wr_address, frame_err, timeout_err);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, registered byte/error strobes.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge (and for line high after a break)
// RX_START | half a bit period in, re-checking the start bit
// RX_DATA  | sampling 8 data bits, LSB first, one per bit period
// RX_STOP  | sampling the stop bit, then straight back to RX_IDLE
module uart_rx_byte
    import filter_comm_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       UART_RXD,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);

    rx_state_t   state_q, state_nxt;
    logic        rx_meta, rxd_s;
    logic [TW-1:0] timer_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic        wait_high_q;
    logic        ld_half, ld_full, sample, done_ok, done_err;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta <= 1'b1;
            rxd_s   <= 1'b1;
        end else begin
            rx_meta <= UART_RXD;
            rxd_s   <= rx_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        sample    = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rxd_s && !wait_high_q) begin
                    state_nxt = RX_START;
                    ld_half   = 1'b1;
                end
            end
            RX_START: begin
                if (timer_q == '0) begin
                    if (!rxd_s) begin
                        state_nxt = RX_DATA;
                        ld_full   = 1'b1;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (timer_q == '0) begin
                    sample  = 1'b1;
                    ld_full = 1'b1;
                    if (bit_cnt_q == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (timer_q == '0) begin
                    state_nxt = RX_IDLE;
                    done_ok   = rxd_s;
                    done_err  = !rxd_s;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // A low stop bit arms wait_high so a held-low line reports a single error.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            wait_high_q <= 1'b0;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (ld_half)             timer_q <= HALF;
            else if (ld_full)        timer_q <= FULL;
            else if (timer_q != '0)  timer_q <= timer_q - 1'b1;

            if (state_q == RX_START) bit_cnt_q <= '0;
            else if (sample)         bit_cnt_q <= bit_cnt_q + 1'b1;

            if (sample) shreg_q <= {rxd_s, shreg_q[7:1]};

            if (done_err)   wait_high_q <= 1'b1;
            else if (rxd_s) wait_high_q <= 1'b0;

            byte_valid <= done_ok;
            frame_err  <= done_err;
        end
    end

    assign rx_byte = shreg_q;

endmodule

// File: rtl/result_word_rx.sv
// Reassembles 5 UART bytes (LSB byte first) into 40-bit result words with a wrapping address.
// Optional inter-byte timeout is enabled with `define RESULT_RX_TIMEOUT_EN.
module result_word_rx #(
    parameter int CLK_HZ = filter_comm_pkg::CLK_HZ_DEF,
    parameter int BAUD   = filter_comm_pkg::BAUD_DEF,
    parameter int ADDR_W = filter_comm_pkg::ADDR_W
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             UART_RXD,
    result_word_rx_if.master bus
);
    import filter_comm_pkg::*;

    localparam int DIV = bit_div(CLK_HZ, BAUD);
    localparam int IW  = $clog2(WORD_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

    logic [7:0]                  rx_byte;
    logic                        byte_valid, frame_err;
    logic [IW-1:0]               idx_q;
    logic [8*(WORD_BYTES-1)-1:0] part_q;
    logic [WORD_W-1:0]           word_q;
    logic                        word_valid_q;
    logic [ADDR_W-1:0]           addr_q;
    logic                        tmo_hit;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .UART_RXD   (UART_RXD),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Partial bytes live in part_q; word_q only moves on a complete word.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_q        <= '0;
            part_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (word_valid_q) addr_q <= addr_q + 1'b1;
            if (frame_err || tmo_hit) begin
                idx_q <= '0;
            end else if (byte_valid) begin
                if (idx_q == LAST_IDX) begin
                    word_q       <= {rx_byte, part_q};
                    word_valid_q <= 1'b1;
                    idx_q        <= '0;
                end else begin
                    part_q[{idx_q, 3'b000} +: 8] <= rx_byte;
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

`ifdef RESULT_RX_TIMEOUT_EN
    // Counts clock cycles equivalent to TIMEOUT_BITS bit periods.
    localparam int TMO_CYC = TIMEOUT_BITS * DIV;
    localparam int TMW     = $clog2(TMO_CYC);

    logic [TMW-1:0] tmo_q;
    logic           tmo_err_q;

    assign tmo_hit = (idx_q != '0) && !byte_valid && !frame_err && (tmo_q == '0);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_q     <= TMW'(TMO_CYC - 1);
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_hit;
            if (idx_q == '0 || byte_valid) tmo_q <= TMW'(TMO_CYC - 1);
            else if (tmo_q != '0)          tmo_q <= tmo_q - 1'b1;
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.word_data  = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.wr_address = addr_q;
    assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_result_word_rx.sv
// Scoreboard bench for result_word_rx: randomized UART bytes against a queue-based word model.
module tb_result_word_rx;
    import filter_comm_pkg::*;

    localparam int TB_CLK_HZ = 50_000_000;
    localparam int TB_BAUD   = 6_250_000;
    localparam int DIV       = 8;
    localparam int AW        = 4;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    logic UART_RXD = 1'b1;

    always #10 CLOCK_50 = ~CLOCK_50;

    result_word_rx_if #(.WORD_W(WORD_W), .ADDR_W(AW)) bus ();

    result_word_rx #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD), .ADDR_W(AW)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .UART_RXD (UART_RXD),
        .bus      (bus)
    );

    typedef struct {
        logic [WORD_W-1:0] data;
        logic [AW-1:0]     addr;
    } exp_t;

    exp_t              exp_q[$];
    logic [7:0]        part_m[$];
    logic [AW-1:0]     addr_m   = '0;
    logic [WORD_W-1:0] last_exp = '0;
    int checks = 0, errors = 0;
    int fe_exp = 0, fe_seen = 0, to_exp = 0, to_seen = 0, held_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: collect good bytes, emit a word every WORD_BYTES of them.
    task automatic model_good(input logic [7:0] b);
        logic [WORD_W-1:0] w;
        exp_t e;
        part_m.push_back(b);
        if (part_m.size() == WORD_BYTES) begin
            w = '0;
            for (int k = 0; k < WORD_BYTES; k++) w[8*k +: 8] = part_m[k];
            e.data = w;
            e.addr = addr_m;
            exp_q.push_back(e);
            addr_m = addr_m + 1'b1;
            part_m.delete();
        end
    endtask

    task automatic model_bad();
        part_m.delete();
        fe_exp++;
    endtask

    task automatic idle(input int n);
        UART_RXD = 1'b1;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) model_good(b);
        else         model_bad();
        UART_RXD = 1'b0;
        repeat (DIV) @(negedge CLOCK_50);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = b[i];
            repeat (DIV) @(negedge CLOCK_50);
        end
        UART_RXD = stop_ok;
        repeat (DIV) @(negedge CLOCK_50);
        if (!stop_ok) idle(DIV);
        UART_RXD = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 6 * DIV && exp_q.size() != 0; i++) @(negedge CLOCK_50);
        check({name, " pending words"}, 64'(exp_q.size()), 64'd0);
        idle(2 * DIV);
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (RESET_N) begin
            if (bus.frame_err)   fe_seen++;
            if (bus.timeout_err) to_seen++;
            if (bus.word_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected word_valid: got word %0h addr %0d, expected none",
                             bus.word_data, bus.wr_address);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(bus.word_data), 64'(e.data));
                    check("wr_address", 64'(bus.wr_address), 64'(e.addr));
                    last_exp = e.data;
                end
            end else if (bus.word_data !== last_exp) begin
                held_bad++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        repeat (4) @(negedge CLOCK_50);
        check("reset word_data",   64'(bus.word_data),   64'd0);
        check("reset word_valid",  64'(bus.word_valid),  64'd0);
        check("reset wr_address",  64'(bus.wr_address),  64'd0);
        check("reset frame_err",   64'(bus.frame_err),   64'd0);
        check("reset timeout_err", 64'(bus.timeout_err), 64'd0);
        RESET_N = 1'b1;
        idle(3);

        // Known word 0x5544332211 at address 0, then a second word at address 1.
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'(8'h11 * (k + 1)), 1'b1);
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drain("basic");

        // Third byte with a low stop bit drops the partial word.
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drain("frame");
        check("frame_err count after bad stop", 64'(fe_seen), 64'(fe_exp));

        // Short low glitch must not start a byte.
        UART_RXD = 1'b0;
        repeat (DIV / 4) @(negedge CLOCK_50);
        idle(3 * DIV);
        check("frame_err count after glitch", 64'(fe_seen), 64'(fe_exp));
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drain("glitch");

        // Break: line held low gives exactly one frame error.
        model_bad();
        UART_RXD = 1'b0;
        repeat (30 * DIV) @(negedge CLOCK_50);
        idle(2 * DIV);
        check("frame_err count after break", 64'(fe_seen), 64'(fe_exp));
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drain("break");

        // Random words with small inter-byte gaps; enough to wrap the address.
        for (int w = 0; w < 20; w++) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                b = 8'($urandom_range(0, 255));
                send_byte(b, 1'b1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain("random");

`ifdef RESULT_RX_TIMEOUT_EN
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        idle(25 * DIV);
        part_m.delete();
        to_exp++;
        check("timeout_err count", 64'(to_seen), 64'(to_exp));
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drain("timeout");
`endif

        // Reset after two bytes: partial data and address both restart.
        send_byte(8'hEE, 1'b1);
        send_byte(8'hDD, 1'b1);
        #2;
        RESET_N  = 1'b0;
        last_exp = '0;
        addr_m   = '0;
        part_m.delete();
        repeat (3) @(negedge CLOCK_50);
        check("mid reset word_data",  64'(bus.word_data),  64'd0);
        check("mid reset wr_address", 64'(bus.wr_address), 64'd0);
        RESET_N = 1'b1;
        idle(3);
        for (int k = 0; k < WORD_BYTES; k++) send_byte(8'(8'hA0 + k), 1'b1);
        check("post-reset expected word", 64'(exp_q.size() ? exp_q[0].data : '0), 64'h00A4A3A2A1A0);
        drain("reset");

        check("word_data held between strobes", 64'(held_bad), 64'd0);
        check("total frame_err pulses", 64'(fe_seen), 64'(fe_exp));
        check("total timeout_err pulses", 64'(to_seen), 64'(to_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
